// File: rtl/v2t_gain_cal_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Packages   : const_pack, v2t_cal_pack
// Description: Shared ADC geometry constants and the V2T gain calibration
//              types (FSM state encoding, control code type, widths).
// Revision   : 1.0 - initial release
// ============================================================================

package const_pack;
    // Number of time-interleaved slices
    localparam int Nti  = 16;
    // Signed ADC code width
    localparam int Nadc = 8;
endpackage

package v2t_cal_pack;
    import const_pack::*;

    // log2 of valid sample sets per accumulation window
    localparam int LOG2_NAVG = 8;
    // V2T control code width
    localparam int CTL_W     = 5;
    // Accumulator width: worst case 2^(Nadc-1) * 2^LOG2_NAVG fits without overflow
    localparam int ACC_W     = Nadc + LOG2_NAVG;
    // Width of the slice index used while comparing
    localparam int KIDX_W    = $clog2(Nti);

    typedef logic [CTL_W-1:0] ctl_code_t;

    // Calibration FSM state encoding
    typedef logic [2:0] v2t_cal_state_t;
    localparam v2t_cal_state_t ST_IDLE  = 3'd0;
    localparam v2t_cal_state_t ST_CLR   = 3'd1;
    localparam v2t_cal_state_t ST_ACCUM = 3'd2;
    localparam v2t_cal_state_t ST_CMP   = 3'd3;
    localparam v2t_cal_state_t ST_FIN   = 3'd4;

    // Legal control code range; code 0 is never produced
    localparam ctl_code_t CTL_MIN = ctl_code_t'(1);
    localparam ctl_code_t CTL_MAX = '1;

    // Magnitude of a signed ADC code; -2^(Nadc-1) maps to 2^(Nadc-1) as unsigned
    function automatic logic [Nadc-1:0] abs_code(input logic [Nadc-1:0] x);
        return x[Nadc-1] ? (~x + 1'b1) : x;
    endfunction
endpackage

`default_nettype wire

// File: rtl/v2t_gain_cal_abs_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : v2t_abs_accum
// Description: Per-slice |code| accumulator. Clears on clr_i, adds the
//              magnitude of in_i on every en_i cycle.
// Revision   : 1.0 - initial release
// ============================================================================

module v2t_abs_accum
    import const_pack::*;
    import v2t_cal_pack::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Nadc-1:0]  in_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [Nadc-1:0]  mag;

    // Next accumulator value: clear has priority over accumulation
    always_comb begin
        mag   = abs_code(in_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W-Nadc){1'b0}}, mag};
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/v2t_gain_cal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : v2t_gain_cal
// Description: On-chip V2T gain calibration engine. Accumulates |code| per
//              slice over a window, compares against target +- deadband and
//              steps each slice's V2T control code by one per pass until all
//              slices sit in the deadband or the pass limit is hit.
// Revision   : 1.0 - initial release
// ============================================================================

module v2t_gain_cal
    import const_pack::*;
    import v2t_cal_pack::*;
#(
    parameter int CTL_NOM  = 6,
    parameter int MAX_ITER = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   adc_valid_i,
    input  logic [Nti*Nadc-1:0]    adc_in_i,
    input  logic [ACC_W-1:0]       target_sum_i,
    input  logic [ACC_W-1:0]       deadband_i,
    output logic [Nti*CTL_W-1:0]   ctl_v2tp_o,
    output logic [Nti*CTL_W-1:0]   ctl_v2tn_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   converged_o,
    output logic [Nti-1:0]         sat_o
);

    localparam int                  PASS_W    = $clog2(MAX_ITER + 1);
    localparam logic [PASS_W-1:0]   PASS_LAST = PASS_W'(MAX_ITER);
    localparam logic [LOG2_NAVG-1:0] SAMP_LAST = '1;
    localparam logic [KIDX_W-1:0]   K_LAST    = KIDX_W'(Nti - 1);
    localparam ctl_code_t           CODE_NOM  = ctl_code_t'(CTL_NOM);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    v2t_cal_state_t      state_q,  state_d;
    logic [LOG2_NAVG-1:0] samp_q,  samp_d;
    logic [KIDX_W-1:0]   k_q,      k_d;
    logic [PASS_W-1:0]   pass_q,   pass_d;
    logic                chg_q,    chg_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                conv_q,   conv_d;
    logic [Nti-1:0]      sat_q,    sat_d;
    ctl_code_t           code_q [Nti];
    ctl_code_t           code_d [Nti];

    // ------------------------------------------------------------------
    // Per-slice accumulators
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_w [Nti];
    logic             acc_clr;
    logic             acc_en;

    assign acc_clr = (state_q == ST_CLR);
    assign acc_en  = (state_q == ST_ACCUM) && adc_valid_i;

    generate
        for (genvar gi = 0; gi < Nti; gi++) begin : g_slice
            v2t_abs_accum u_accum (
                .clk   (clk),
                .rst   (rst),
                .clr_i (acc_clr),
                .en_i  (acc_en),
                .in_i  (adc_in_i[gi*Nadc +: Nadc]),
                .acc_o (acc_w[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compare datapath for the slice currently indexed by k_q
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   thr_hi;
    logic [ACC_W:0]   thr_lo;
    ctl_code_t        cur_code;
    logic             go_down;
    logic             go_up;
    logic             at_min;
    logic             at_max;
    logic             step_dn;
    logic             step_up;
    logic             clamp;
    logic             chg_now;

    // Threshold window and step decision; one extra bit keeps both bounds exact
    always_comb begin
        acc_sel  = acc_w[k_q];
        acc_ext  = {1'b0, acc_sel};
        // Sum of two ACC_W values never exceeds 2^(ACC_W+1)-1, so no wrap here
        thr_hi   = {1'b0, target_sum_i} + {1'b0, deadband_i};
        // Lower bound floors at zero instead of wrapping
        thr_lo   = (target_sum_i >= deadband_i) ? {1'b0, target_sum_i - deadband_i} : '0;
        cur_code = code_q[k_q];
        go_down  = (acc_ext > thr_hi);
        go_up    = (acc_ext < thr_lo);
        at_min   = (cur_code <= CTL_MIN);
        at_max   = (cur_code == CTL_MAX);
        step_dn  = go_down && !at_min;
        step_up  = go_up && !at_max;
        clamp    = (go_down && at_min) || (go_up && at_max);
        chg_now  = chg_q || step_dn || step_up;
    end

    // ------------------------------------------------------------------
    // FSM and register next-state
    // ------------------------------------------------------------------
    // Sequencing of clear / accumulate / compare passes and code updates
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        k_d     = k_q;
        pass_d  = pass_q;
        chg_d   = chg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        conv_d  = conv_q;
        sat_d   = sat_q;
        for (int i = 0; i < Nti; i++) begin
            code_d[i] = code_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                // Codes are kept so a new run continues from the last result
                if (start_i) begin
                    state_d = ST_CLR;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                    sat_d   = '0;
                    pass_d  = '0;
                end
            end

            ST_CLR: begin
                samp_d  = '0;
                k_d     = '0;
                chg_d   = 1'b0;
                state_d = ST_ACCUM;
            end

            ST_ACCUM: begin
                if (adc_valid_i) begin
                    samp_d = samp_q + 1'b1;
                    if (samp_q == SAMP_LAST) begin
                        state_d = ST_CMP;
                    end
                end
            end

            ST_CMP: begin
                if (step_dn) begin
                    code_d[k_q] = cur_code - 1'b1;
                    chg_d       = 1'b1;
                end else if (step_up) begin
                    code_d[k_q] = cur_code + 1'b1;
                    chg_d       = 1'b1;
                end
                if (clamp) begin
                    sat_d[k_q] = 1'b1;
                end
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    pass_d = pass_q + 1'b1;
                    if (!chg_now) begin
                        state_d = ST_FIN;
                        conv_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if ((pass_q + 1'b1) == PASS_LAST) begin
                        state_d = ST_FIN;
                        conv_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CLR;
                    end
                end
            end

            ST_FIN: begin
                // start is not looked at here, so a pulse in this cycle is dropped
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and code registers; reset restores nominal codes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            samp_q  <= '0;
            k_q     <= '0;
            pass_q  <= '0;
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            sat_q   <= '0;
            for (int i = 0; i < Nti; i++) begin
                code_q[i] <= CODE_NOM;
            end
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            k_q     <= k_d;
            pass_q  <= pass_d;
            chg_q   <= chg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            sat_q   <= sat_d;
            for (int i = 0; i < Nti; i++) begin
                code_q[i] <= code_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    generate
        for (genvar go = 0; go < Nti; go++) begin : g_out
            assign ctl_v2tp_o[go*CTL_W +: CTL_W] = code_q[go];
            assign ctl_v2tn_o[go*CTL_W +: CTL_W] = code_q[go];
        end
    endgenerate

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign converged_o = conv_q;
    assign sat_o       = sat_q;

endmodule

`default_nettype wire
